icache_dm: RTL

Direct-mapped, read-only instruction cache that answers the IFU memory port (ren/addr/rData/hit/rvalid) and refills from main memory over a simple AR/R burst read port.
- Hits report combinationally in the request cycle.
- Misses stall the IFU until the refill completes, then pulse rvalid.
- Sits between the IFU and the memory/crossbar. Also provides fence.i invalidate and hit/miss performance counters.

---
 rtl/icache_pkg.sv | 42 ++++
 rtl/icache_dm_array.sv | 73 +++++++
 rtl/icache_dm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and geometry for the direct-mapped instruction cache.
//   state_t         : refill controller states
//   calc_*_w()      : address-field widths derived from a cache geometry
//   OFF_W .. TAG_W  : field widths for the default geometry (16 sets x 2 beats)
//   RESET_ADDR      : first fetch address, shared with the fetch stage
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int unsigned NSETS_DEF      = 16;
    localparam int unsigned LINE_BEATS_DEF = 2;

    localparam logic [31:0] RESET_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    // Byte-offset bits within a line (8-byte beats).
    function automatic int unsigned calc_off_w(input int unsigned line_beats);
        return 3 + $clog2(line_beats);
    endfunction

    // Beat-select width; kept at least 1 so a one-beat line still has a counter.
    function automatic int unsigned calc_beat_w(input int unsigned line_beats);
        return (line_beats > 1) ? $clog2(line_beats) : 1;
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned nsets);
        return $clog2(nsets);
    endfunction

    localparam int unsigned OFF_W  = calc_off_w(LINE_BEATS_DEF);
    localparam int unsigned BEAT_W = calc_beat_w(LINE_BEATS_DEF);
    localparam int unsigned IDX_W  = calc_idx_w(NSETS_DEF);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;

endpackage

// File: rtl/icache_dm_array.sv
// -----------------------------------------------------------------------------
// icache_dm_array
// Tag, data and valid storage for the direct-mapped cache.
//   clock, reset      : system clock, synchronous active-high reset
//   flush_all_i       : clear every valid bit at the next edge
//   rd_idx_i/beat_i   : combinational read port -> rd_valid_o, rd_tag_o, rd_data_o
//   wr_idx_i/beat_i   : write address shared by the data and tag writes
//   wr_data_en_i      : write one 64-bit beat
//   wr_tag_en_i       : write the line tag and load its valid bit with wr_valid_i
// -----------------------------------------------------------------------------
module icache_dm_array
    import icache_pkg::*;
#(
    parameter int unsigned NSETS      = NSETS_DEF,
    parameter int unsigned LINE_BEATS = LINE_BEATS_DEF,
    parameter int unsigned IDX_BITS   = calc_idx_w(NSETS),
    parameter int unsigned BEAT_BITS  = calc_beat_w(LINE_BEATS),
    parameter int unsigned TAG_BITS   = 32 - calc_off_w(LINE_BEATS) - IDX_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_all_i,
    input  logic [IDX_BITS-1:0]  rd_idx_i,
    input  logic [BEAT_BITS-1:0] rd_beat_i,
    output logic                 rd_valid_o,
    output logic [TAG_BITS-1:0]  rd_tag_o,
    output logic [63:0]          rd_data_o,
    input  logic [IDX_BITS-1:0]  wr_idx_i,
    input  logic [BEAT_BITS-1:0] wr_beat_i,
    input  logic                 wr_data_en_i,
    input  logic [63:0]          wr_data_i,
    input  logic                 wr_tag_en_i,
    input  logic [TAG_BITS-1:0]  wr_tag_i,
    input  logic                 wr_valid_i
);

    localparam int unsigned DEPTH = NSETS * LINE_BEATS;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [NSETS-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [NSETS];
    logic [63:0]         data_q [DEPTH];
    logic [AW-1:0]       rd_addr, wr_addr;

    // Data is laid out line-major: all beats of set 0, then set 1, ...
    assign rd_addr = AW'(int'(rd_idx_i) * LINE_BEATS + int'(rd_beat_i));
    assign wr_addr = AW'(int'(wr_idx_i) * LINE_BEATS + int'(wr_beat_i));

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_addr];

    // Flush wins over a same-cycle tag write so an invalidate is never lost.
    always_ff @(posedge clock) begin
        if (reset || flush_all_i) begin
            valid_q <= '0;
        end else if (wr_tag_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // NOTE: tag and data arrays carry no reset; valid_q gates every use of
    // them, and leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_data_en_i) begin
            data_q[wr_addr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm
// Direct-mapped read-only instruction cache between the IFU and memory.
//   clock, reset        : system clock, synchronous active-high reset
//   ioMem_*             : IFU lookup port; hit is combinational, misses stall
//                         until a one-cycle rvalid pulse
//   flush               : fence.i, invalidate every line
//   mem_ar* / mem_r*    : line refill burst-read port
//   perf_hits/misses    : wrapping 32-bit performance counters
// -----------------------------------------------------------------------------
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned NSETS      = NSETS_DEF,
    parameter int unsigned LINE_BEATS = LINE_BEATS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioMem_ren,
    input  logic [31:0] ioMem_addr,
    output logic [63:0] ioMem_rData,
    output logic        ioMem_hit,
    output logic        ioMem_rvalid,
    input  logic        flush,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rlast,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
);

    localparam int unsigned OFF_BITS  = calc_off_w(LINE_BEATS);
    localparam int unsigned BEAT_BITS = calc_beat_w(LINE_BEATS);
    localparam int unsigned IDX_BITS  = calc_idx_w(NSETS);
    localparam int unsigned TAG_BITS  = 32 - OFF_BITS - IDX_BITS;

    state_t               state_q, state_d;
    logic [31:0]          req_addr_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic [63:0]          rdata_q;
    logic                 flush_pend_q;
    logic [31:0]          perf_hits_q, perf_misses_q;

    logic [IDX_BITS-1:0]  lk_idx, req_idx;
    logic [TAG_BITS-1:0]  lk_tag, req_tag, arr_tag;
    logic [BEAT_BITS-1:0] lk_beat, req_beat;
    logic                 arr_valid;
    logic [63:0]          arr_data;
    logic                 miss_start, beat_fire, last_beat, flush_all, set_valid;

    // Address split for the live request and for the latched miss address.
    assign lk_idx   = ioMem_addr[OFF_BITS +: IDX_BITS];
    assign lk_tag   = ioMem_addr[31 -: TAG_BITS];
    assign lk_beat  = BEAT_BITS'((ioMem_addr >> 3) & (LINE_BEATS - 1));
    assign req_idx  = req_addr_q[OFF_BITS +: IDX_BITS];
    assign req_tag  = req_addr_q[31 -: TAG_BITS];
    assign req_beat = BEAT_BITS'((req_addr_q >> 3) & (LINE_BEATS - 1));

    // A flush in the lookup cycle invalidates the line being looked up, so the
    // request has to take the miss path.
    assign ioMem_hit  = (state_q == IDLE) && ioMem_ren && !flush
                        && arr_valid && (arr_tag == lk_tag);
    assign miss_start = (state_q == IDLE) && ioMem_ren && !ioMem_hit;
    assign beat_fire  = (state_q == FILL) && mem_rvalid;
    assign last_beat  = beat_fire
                        && (mem_rlast || (beat_q == BEAT_BITS'(LINE_BEATS - 1)));

    // A flush seen during a refill must leave the refilled line invalid and
    // clear everything once the controller is back in IDLE.
    assign set_valid = !(flush_pend_q || flush);
    assign flush_all = ((state_q == IDLE) && flush)
                       || ((state_q == RESP) && (flush_pend_q || flush));

    icache_dm_array #(
        .NSETS      (NSETS),
        .LINE_BEATS (LINE_BEATS),
        .IDX_BITS   (IDX_BITS),
        .BEAT_BITS  (BEAT_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .flush_all_i  (flush_all),
        .rd_idx_i     (lk_idx),
        .rd_beat_i    (lk_beat),
        .rd_valid_o   (arr_valid),
        .rd_tag_o     (arr_tag),
        .rd_data_o    (arr_data),
        .wr_idx_i     (req_idx),
        .wr_beat_i    (beat_q),
        .wr_data_en_i (beat_fire),
        .wr_data_i    (mem_rdata),
        .wr_tag_en_i  (last_beat),
        .wr_tag_i     (req_tag),
        .wr_valid_i   (set_valid)
    );

    // NOTE: state_d takes its hold value before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss_start)  state_d = REQ;
            REQ:     if (mem_arready) state_d = FILL;
            FILL:    if (last_beat)   state_d = RESP;
            RESP:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            beat_q        <= '0;
            rdata_q       <= '0;
            flush_pend_q  <= 1'b0;
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            state_q <= state_d;

            if (miss_start) begin
                req_addr_q    <= ioMem_addr;
                perf_misses_q <= perf_misses_q + 32'd1;
            end

            if (ioMem_hit) begin
                rdata_q     <= arr_data;
                perf_hits_q <= perf_hits_q + 32'd1;
            end

            if (state_q == REQ) begin
                beat_q <= '0;
            end else if (beat_fire) begin
                beat_q <= beat_q + BEAT_BITS'(1);
                if (beat_q == req_beat) begin
                    rdata_q <= mem_rdata;
                end
            end

            if (state_q == RESP) begin
                flush_pend_q <= 1'b0;
            end else if ((state_q != IDLE) && flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    assign ioMem_rData  = rdata_q;
    assign ioMem_rvalid = (state_q == RESP);
    assign mem_arvalid  = (state_q == REQ);
    assign mem_rready   = (state_q == FILL);
    assign mem_araddr   = {req_addr_q[31:OFF_BITS], {OFF_BITS{1'b0}}};
    assign perf_hits    = perf_hits_q;
    assign perf_misses  = perf_misses_q;

endmodule
